// File: rtl/cache_responder.sv
// Direct-mapped write-back/write-allocate cache slave on the 4-phase request/valid protocol, one word per line.
// Optional hit/miss statistics are compiled in with CACHE_RESPONDER_STATS_EN.
module cache_responder #(
  parameter int DATAWIDTH    = 8,
  parameter int ADDRESSWIDTH = 32,
  parameter int INDEXBITS    = 4
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [1:0]              operation,
  input  logic [ADDRESSWIDTH-1:0] addr,
  input  logic [DATAWIDTH-1:0]    d_in,
  output logic [DATAWIDTH-1:0]    d_out,
  output logic                    d_oe,
  input  logic                    request,
  output logic                    valid,
  output logic                    evict,
  output logic                    mem_req,
  output logic                    mem_we,
  output logic [ADDRESSWIDTH-1:0] mem_addr,
  output logic [DATAWIDTH-1:0]    mem_wdata,
  input  logic [DATAWIDTH-1:0]    mem_rdata,
  input  logic                    mem_ack,
  output logic [31:0]             hit_count,
  output logic [31:0]             miss_count
);
  localparam int LINES = 2**INDEXBITS;
  localparam int TAGW  = ADDRESSWIDTH - INDEXBITS;
  localparam logic [1:0] OP_READ = 2'b00, OP_WRITE = 2'b01, OP_INV = 2'b10;

  typedef enum logic [2:0] {IDLE, LOOKUP, WRITEBACK, FILL, RESPOND} state_t;

  state_t                  state, next_state;
  logic [1:0]              op_q;
  logic [ADDRESSWIDTH-1:0] addr_q;
  logic [DATAWIDTH-1:0]    d_q;
  logic                    evict_flag, set_evict;
  logic [LINES-1:0]        line_valid, line_dirty;
  logic [TAGW-1:0]         tag_mem  [LINES];
  logic [DATAWIDTH-1:0]    data_mem [LINES];
  logic [INDEXBITS-1:0]    idx;
  logic [TAGW-1:0]         tag;
  logic                    hit, rw_op;

  assign idx   = addr_q[INDEXBITS-1:0];
  assign tag   = addr_q[ADDRESSWIDTH-1:INDEXBITS];
  assign hit   = line_valid[idx] && (tag_mem[idx] == tag);
  assign rw_op = (op_q == OP_READ) || (op_q == OP_WRITE);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    set_evict  = 1'b0;
    case (state)
      IDLE:    if (request) next_state = LOOKUP;
      LOOKUP: begin
        if (rw_op) begin
          if (hit) next_state = RESPOND;
          else if (line_valid[idx] && line_dirty[idx]) begin
            set_evict  = 1'b1;
            next_state = WRITEBACK;
          end else next_state = FILL;
        end else if (op_q == OP_INV && hit && line_dirty[idx]) begin
          set_evict  = 1'b1;
          next_state = WRITEBACK;
        end else next_state = RESPOND;
      end
      WRITEBACK: if (mem_ack) next_state = (op_q == OP_INV) ? RESPOND : FILL;
      FILL:      if (mem_ack) next_state = RESPOND;
      RESPOND:   if (!request) next_state = IDLE;
      default:   next_state = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      op_q       <= '0;
      addr_q     <= '0;
      d_q        <= '0;
      evict_flag <= 1'b0;
      line_valid <= '0;
      line_dirty <= '0;
      d_out      <= '0;
    end else begin
      if (state == IDLE && request) begin
        op_q   <= operation;
        addr_q <= addr;
        d_q    <= d_in;
      end
      if (set_evict) evict_flag <= 1'b1;
      else if (state == RESPOND && !request) evict_flag <= 1'b0;
      if (state == LOOKUP && hit) begin
        if (op_q == OP_READ)  d_out <= data_mem[idx];
        if (op_q == OP_WRITE) line_dirty[idx] <= 1'b1;
        // A clean hit is dropped here; an invalidate miss must not touch the other tag's line.
        if (op_q == OP_INV && !line_dirty[idx]) line_valid[idx] <= 1'b0;
      end
      if (state == WRITEBACK && mem_ack) begin
        line_dirty[idx] <= 1'b0;
        if (op_q == OP_INV) line_valid[idx] <= 1'b0;
      end
      if (state == FILL && mem_ack) begin
        line_valid[idx] <= 1'b1;
        line_dirty[idx] <= (op_q == OP_WRITE);
        if (op_q == OP_READ) d_out <= mem_rdata;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (state == LOOKUP && hit && op_q == OP_WRITE) data_mem[idx] <= d_q;
    if (state == FILL && mem_ack) begin
      tag_mem[idx]  <= tag;
      data_mem[idx] <= (op_q == OP_WRITE) ? d_q : mem_rdata;
    end
  end

  assign valid     = (state == RESPOND);
  assign evict     = valid && evict_flag;
  assign d_oe      = valid && (op_q == OP_READ);
  assign mem_req   = (state == WRITEBACK) || (state == FILL);
  assign mem_we    = (state == WRITEBACK);
  assign mem_addr  = (state == WRITEBACK) ? {tag_mem[idx], idx} :
                     (state == FILL)      ? addr_q : '0;
  assign mem_wdata = (state == WRITEBACK) ? data_mem[idx] : '0;

`ifdef CACHE_RESPONDER_STATS_EN
  logic count_hit, count_miss;
  assign count_hit  = (state == LOOKUP) && rw_op && hit;
  assign count_miss = (state == LOOKUP) && rw_op && !hit;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      if (count_hit && hit_count != 32'hFFFF_FFFF)   hit_count  <= hit_count + 32'd1;
      if (count_miss && miss_count != 32'hFFFF_FFFF) miss_count <= miss_count + 32'd1;
    end
  end
`else
  assign hit_count  = '0;
  assign miss_count = '0;
`endif
endmodule

// File: tb/tb_cache_responder.sv
// Directed bench for cache_responder: reset, fills, hits, dirty evictions, invalidate, reset mid-fill, slow ack.
module tb_cache_responder;
  logic        clock = 1'b0, reset = 1'b0, request = 1'b0, mem_ack = 1'b0;
  logic [1:0]  operation = 2'b11;
  logic [31:0] addr = '0;
  logic [7:0]  d_in = '0, mem_rdata = '0;
  logic [7:0]  d_out, mem_wdata;
  logic        d_oe, valid, evict, mem_req, mem_we;
  logic [31:0] mem_addr, hit_count, miss_count;
  int checks = 0, errors = 0;

  cache_responder dut (
    .clock(clock), .reset(reset), .operation(operation), .addr(addr), .d_in(d_in),
    .d_out(d_out), .d_oe(d_oe), .request(request), .valid(valid), .evict(evict),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .hit_count(hit_count), .miss_count(miss_count)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock); #1;
  endtask

  task automatic start(input logic [1:0] op, input logic [31:0] a, input logic [7:0] d);
    operation = op; addr = a; d_in = d; request = 1'b1;
  endtask

  task automatic wait_mem_req();
    for (int i = 0; i < 40 && !mem_req; i++) tick();
  endtask

  // Waits for mem_req, records what was presented, then acknowledges after `delay` cycles.
  task automatic mem_handshake(input logic [7:0] rdata, input int delay, output bit got,
                               output logic we, output logic [31:0] a, output logic [7:0] wd);
    got = 1'b0; we = 1'b0; a = '0; wd = '0;
    wait_mem_req();
    if (mem_req) begin
      got = 1'b1; we = mem_we; a = mem_addr; wd = mem_wdata;
      repeat (delay) tick();
      mem_ack = 1'b1; mem_rdata = rdata;
      tick();
      mem_ack = 1'b0;
    end
  endtask

  task automatic test_reset();
    #1;
    checks++; if ({valid, evict, d_oe, mem_req, mem_we} !== 5'b0) begin errors++; $display("FAIL reset_ctrl: got %b want 00000", {valid, evict, d_oe, mem_req, mem_we}); end
    checks++; if ({d_out, mem_wdata, mem_addr} !== '0) begin errors++; $display("FAIL reset_data: got %h/%h/%h want 0", d_out, mem_wdata, mem_addr); end
    checks++; if ({hit_count, miss_count} !== '0) begin errors++; $display("FAIL reset_counters: got %0d/%0d want 0/0", hit_count, miss_count); end
    @(negedge clock); reset = 1'b1;
    tick();
  endtask

  task automatic test_read_miss();
    bit got; logic we; logic [31:0] a; logic [7:0] wd;
    start(2'b00, 32'h13, 8'h00);
    mem_handshake(8'hA5, 0, got, we, a, wd);
    checks++; if ({got, we, a} !== {1'b1, 1'b0, 32'h13}) begin errors++; $display("FAIL miss_fill: got req=%b we=%b addr=%h want 1 0 00000013", got, we, a); end
    checks++; if ({valid, d_oe, evict, d_out} !== {3'b110, 8'hA5}) begin errors++; $display("FAIL miss_resp: got v=%b oe=%b ev=%b d=%h want 1 1 0 a5", valid, d_oe, evict, d_out); end
    request = 1'b0;
    tick();
    checks++; if ({valid, d_oe} !== 2'b00) begin errors++; $display("FAIL miss_release: got v=%b oe=%b want 0 0", valid, d_oe); end
  endtask

  task automatic test_read_hit();
    mem_ack = 1'b1; mem_rdata = 8'hFF;
    tick();
    mem_ack = 1'b0;
    checks++; if ({valid, mem_req} !== 2'b00) begin errors++; $display("FAIL stray_ack: got v=%b req=%b want 0 0", valid, mem_req); end
    start(2'b00, 32'h13, 8'h00);
    tick();
    checks++; if ({valid, mem_req} !== 2'b00) begin errors++; $display("FAIL hit_lookup: got v=%b req=%b want 0 0", valid, mem_req); end
    tick();
    checks++; if ({valid, d_oe, mem_req, d_out} !== {3'b110, 8'hA5}) begin errors++; $display("FAIL hit_resp: got v=%b oe=%b req=%b d=%h want 1 1 0 a5", valid, d_oe, mem_req, d_out); end
`ifdef CACHE_RESPONDER_STATS_EN
    checks++; if ({hit_count, miss_count} !== {32'd1, 32'd1}) begin errors++; $display("FAIL hit_stats: got %0d/%0d want 1/1", hit_count, miss_count); end
`else
    checks++; if ({hit_count, miss_count} !== '0) begin errors++; $display("FAIL hit_stats: got %0d/%0d want 0/0", hit_count, miss_count); end
`endif
    request = 1'b0;
    tick();
  endtask

  task automatic test_dirty_evict();
    bit got; logic we; logic [31:0] a; logic [7:0] wd;
    start(2'b01, 32'h13, 8'h5A);
    tick(); tick();
    checks++; if ({valid, evict, d_oe, mem_req} !== 4'b1000) begin errors++; $display("FAIL wr_hit: got v=%b ev=%b oe=%b req=%b want 1 0 0 0", valid, evict, d_oe, mem_req); end
    request = 1'b0; tick();
    start(2'b00, 32'h103, 8'h00);
    mem_handshake(8'h00, 0, got, we, a, wd);
    checks++; if ({got, we, a, wd} !== {2'b11, 32'h13, 8'h5A}) begin errors++; $display("FAIL evict_wb: got req=%b we=%b addr=%h wd=%h want 1 1 00000013 5a", got, we, a, wd); end
    mem_handshake(8'h3C, 0, got, we, a, wd);
    checks++; if ({got, we, a} !== {2'b10, 32'h103}) begin errors++; $display("FAIL evict_fill: got req=%b we=%b addr=%h want 1 0 00000103", got, we, a); end
    checks++; if ({valid, evict, d_oe, d_out} !== {3'b111, 8'h3C}) begin errors++; $display("FAIL evict_resp: got v=%b ev=%b oe=%b d=%h want 1 1 1 3c", valid, evict, d_oe, d_out); end
    request = 1'b0; tick();
    checks++; if ({valid, evict} !== 2'b00) begin errors++; $display("FAIL evict_release: got v=%b ev=%b want 0 0", valid, evict); end
  endtask

  task automatic test_invalidate();
    bit got; logic we; logic [31:0] a; logic [7:0] wd;
    start(2'b01, 32'h24, 8'h77);
    mem_handshake(8'h11, 0, got, we, a, wd);
    checks++; if ({got, we, a, valid, evict} !== {2'b10, 32'h24, 2'b10}) begin errors++; $display("FAIL wr_alloc: got req=%b we=%b addr=%h v=%b ev=%b want 1 0 00000024 1 0", got, we, a, valid, evict); end
    request = 1'b0; tick();
    start(2'b10, 32'h24, 8'h00);
    mem_handshake(8'h00, 0, got, we, a, wd);
    checks++; if ({got, we, a, wd} !== {2'b11, 32'h24, 8'h77}) begin errors++; $display("FAIL inv_wb: got req=%b we=%b addr=%h wd=%h want 1 1 00000024 77", got, we, a, wd); end
    checks++; if ({valid, evict, d_oe, mem_req} !== 4'b1100) begin errors++; $display("FAIL inv_resp: got v=%b ev=%b oe=%b req=%b want 1 1 0 0", valid, evict, d_oe, mem_req); end
    request = 1'b0; tick();
    start(2'b00, 32'h24, 8'h00);
    mem_handshake(8'h22, 0, got, we, a, wd);
    checks++; if ({got, we, a, d_out} !== {2'b10, 32'h24, 8'h22}) begin errors++; $display("FAIL inv_refill: got req=%b we=%b addr=%h d=%h want 1 0 00000024 22", got, we, a, d_out); end
    request = 1'b0; tick();
  endtask

  task automatic test_reset_in_fill();
    bit got; logic we; logic [31:0] a; logic [7:0] wd;
    start(2'b00, 32'h35, 8'h00);
    wait_mem_req();
    checks++; if ({mem_req, mem_we} !== 2'b10) begin errors++; $display("FAIL rst_fill_entry: got req=%b we=%b want 1 0", mem_req, mem_we); end
    @(negedge clock); reset = 1'b0; request = 1'b0; #1;
    checks++; if ({mem_req, valid, d_oe} !== 3'b000) begin errors++; $display("FAIL rst_fill_abort: got req=%b v=%b oe=%b want 0 0 0", mem_req, valid, d_oe); end
    tick();
    @(negedge clock); reset = 1'b1;
    tick();
    start(2'b00, 32'h35, 8'h00);
    mem_handshake(8'h5C, 0, got, we, a, wd);
    checks++; if ({got, we, a, valid, d_out} !== {2'b10, 32'h35, 1'b1, 8'h5C}) begin errors++; $display("FAIL rst_refill: got req=%b we=%b addr=%h v=%b d=%h want 1 0 00000035 1 5c", got, we, a, valid, d_out); end
`ifdef CACHE_RESPONDER_STATS_EN
    checks++; if ({hit_count, miss_count} !== {32'd0, 32'd1}) begin errors++; $display("FAIL rst_stats: got %0d/%0d want 0/1", hit_count, miss_count); end
`endif
    request = 1'b0; tick();
  endtask

  task automatic test_slow_ack();
    int held = 0;
    start(2'b00, 32'h46, 8'h00);
    wait_mem_req();
    for (int i = 0; i < 5; i++) begin
      if (mem_req && !valid) held++;
      tick();
    end
    checks++; if (held !== 5) begin errors++; $display("FAIL slow_hold: got %0d cycles want 5", held); end
    mem_ack = 1'b1; mem_rdata = 8'h9E;
    checks++; if ({mem_req, valid} !== 2'b10) begin errors++; $display("FAIL slow_ack_cycle: got req=%b v=%b want 1 0", mem_req, valid); end
    tick();
    mem_ack = 1'b0;
    checks++; if ({mem_req, valid, d_out} !== {2'b01, 8'h9E}) begin errors++; $display("FAIL slow_after_ack: got req=%b v=%b d=%h want 0 1 9e", mem_req, valid, d_out); end
    request = 1'b0; tick();
  endtask

  task automatic test_back_to_back();
    start(2'b11, 32'h46, 8'h00);
    tick();
    request = 1'b0;
    tick();
    checks++; if ({valid, mem_req, evict} !== 3'b100) begin errors++; $display("FAIL nop_early_drop: got v=%b req=%b ev=%b want 1 0 0", valid, mem_req, evict); end
    tick();
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL nop_pulse: got v=%b want 0", valid); end
    start(2'b00, 32'h46, 8'h00);
    tick(); tick();
    checks++; if ({valid, d_out, mem_req} !== {1'b1, 8'h9E, 1'b0}) begin errors++; $display("FAIL b2b_hit: got v=%b d=%h req=%b want 1 9e 0", valid, d_out, mem_req); end
    request = 1'b0; tick();
  endtask

  initial begin
    test_reset();
    test_read_miss();
    test_read_hit();
    test_dirty_evict();
    test_invalidate();
    test_reset_in_fill();
    test_slow_ack();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
